// File: rtl/wavetable_pkg.sv
// Shared constants and helpers for the wavetable ROM arbiter.
package wavetable_pkg;

  localparam int ROM_SIZE      = 641;
  localparam int WT_AW         = 10;
  localparam int WT_DW         = 8;
  localparam int N_REQ_DEFAULT = 4;
  localparam int MAX_REQ       = 8;

  // Pull voice idx's address out of a packed address bus (voice i at [i*WT_AW +: WT_AW]).
  function automatic logic [WT_AW-1:0] addr_slice(input logic [MAX_REQ*WT_AW-1:0] addrs,
                                                  input int idx);
    return addrs[idx*WT_AW +: WT_AW];
  endfunction

endpackage

// File: rtl/wavetable_rom_arbiter_rr_arbiter.sv
// Generic N-way round-robin arbiter: the search starts at rr_ptr, and the pointer
// moves to one past the winner after every grant.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] winner,
  output logic          grant_any
);

  logic [IW-1:0] rr_ptr;

  // Winner search: first set request at rr_ptr, rr_ptr+1, ... modulo N.
  always_comb begin
    int idx;
    idx       = 0;
    gnt       = '0;
    winner    = '0;
    grant_any = 1'b0;
    if (en) begin
      for (int k = 0; k < N; k++) begin
        idx = (int'(rr_ptr) + k) % N;
        if (!grant_any && req[idx]) begin
          grant_any = 1'b1;
          winner    = IW'(idx);
        end
      end
    end
    if (grant_any) gnt[winner] = 1'b1;
  end

  // Pointer register: advances past the winner on a grant, otherwise holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= (int'(winner) == N - 1) ? '0 : winner + 1'b1;
    end
  end

endmodule

// File: rtl/wavetable_rom_arbiter.sv
// Shares one registered-read wavetable ROM between N_REQ NCO voices.
//
// Handshake: req[i] is a level held with a stable req_addr until gnt[i] is seen
// high at a posedge; gnt is combinational in the same cycle. In the following
// cycle rd_valid[i] is high and rd_data carries that voice's ROM byte. A voice may
// present its next address right after its grant (back-to-back reads).
module wavetable_rom_arbiter #(
  parameter int N_REQ    = wavetable_pkg::N_REQ_DEFAULT,
  parameter int ROM_SIZE = wavetable_pkg::ROM_SIZE,
  parameter int AW       = wavetable_pkg::WT_AW,
  parameter int DW       = wavetable_pkg::WT_DW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*AW-1:0] req_addr,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    rd_valid,
  output logic [DW-1:0]       rd_data,
  output logic                rom_re,
  output logic [AW-1:0]       rom_addr,
  input  logic [DW-1:0]       rom_data,
  output logic                err_oob,
  input  logic                err_clr
);

  import wavetable_pkg::*;

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IW-1:0]              winner;
  logic                       grant_any;
  logic [MAX_REQ*WT_AW-1:0]   addr_pad;
  logic [AW-1:0]              sel_addr;
  logic                       in_range;

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .winner    (winner),
    .grant_any (grant_any)
  );

  assign addr_pad = (MAX_REQ*WT_AW)'(req_addr);
  assign sel_addr = AW'(addr_slice(addr_pad, int'(winner)));
  assign in_range = int'(sel_addr) < ROM_SIZE;

  // Out-of-range grants still read, but from address 0, so the voice is never starved.
  assign rom_re   = grant_any;
  assign rom_addr = (grant_any && in_range) ? sel_addr : '0;
  assign rd_data  = rom_data;

  // Return-path valid: the grant delayed by the ROM's one-cycle read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_valid <= '0;
    else     rd_valid <= gnt;
  end

  // Sticky out-of-range flag; a new violation wins over a clear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        err_oob <= 1'b0;
    else if (grant_any && !in_range) err_oob <= 1'b1;
    else if (err_clr)               err_oob <= 1'b0;
  end

endmodule
